// File: rtl/conv1d_window_feeder.sv
// Sliding-window and weight-table feeder for the Conv1D PE group.
// Streams Para_Deg lanes of one tap per cycle, then slides by Para_Deg.
module conv1d_window_feeder #(
  parameter int Data_Width  = 8,
  parameter int Para_Deg    = 3,
  parameter int Kernel_Size = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             w_wr_en,
  input  logic [$clog2(Kernel_Size)-1:0]   w_wr_addr,
  input  logic [Data_Width-1:0]            w_wr_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [Data_Width-1:0]            in_data,
  output logic [Para_Deg*Data_Width-1:0]   data0,
  output logic [Para_Deg*Data_Width-1:0]   data1,
  output logic                             Initial_Accumulate,
  output logic                             pe_valid,
  output logic                             group_done
);

  localparam int W  = Para_Deg + Kernel_Size - 1;
  localparam int CW = $clog2(W + 1);
  localparam int KW = $clog2(Kernel_Size);
  localparam int SW = $clog2(Para_Deg + 1);

  typedef enum logic [1:0] {FILL, COMPUTE, DONE, SHIFT} state_t;

  state_t                        state, state_d;
  logic [CW-1:0]                 count, count_d;
  logic [KW-1:0]                 k, k_d, tap;
  logic [SW-1:0]                 scnt, scnt_d;
  logic [Data_Width-1:0]         win [W];
  logic [Data_Width-1:0]         win_d [W];
  logic [Data_Width-1:0]         wt [Kernel_Size];
  logic [Data_Width-1:0]         wt_d [Kernel_Size];
  logic [Para_Deg*Data_Width-1:0] d0_d, d1_d;
  logic                          ia_d, pv_d, gd_d;
  logic                          accept, load, last_fill, last_shift, last_tap;

  assign in_ready   = (state == FILL) || (state == SHIFT);
  assign accept     = in_valid && in_ready && !clear;
  assign last_fill  = accept && (state == FILL) &&
                      (count == CW'(W - 1));
  assign last_shift = accept && (state == SHIFT) &&
                      (scnt == SW'(Para_Deg - 1));
  assign last_tap   = (k == KW'(Kernel_Size - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_d;
  end

  // Next-state: clear always wins and returns to FILL
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = FILL;
    end else begin
      unique case (state)
        FILL:    if (last_fill)  state_d = COMPUTE;
        COMPUTE: if (last_tap)   state_d = DONE;
        DONE:                    state_d = SHIFT;
        SHIFT:   if (last_shift) state_d = COMPUTE;
        default:                 state_d = FILL;
      endcase
    end
  end

  // Output/datapath next values; taps load from the post-update
  // window and weights so a same-edge write/sample is seen at tap 0
  always_comb begin
    win_d   = win;
    wt_d    = wt;
    count_d = count;
    k_d     = k;
    scnt_d  = scnt;
    d0_d    = data0;
    d1_d    = data1;
    ia_d    = 1'b0;
    pv_d    = 1'b0;
    gd_d    = 1'b0;
    load    = 1'b0;
    tap     = '0;
    if (clear) begin
      count_d = '0;
      k_d     = '0;
      scnt_d  = '0;
    end else begin
      if (accept) begin
        for (int i = 0; i < W - 1; i++) win_d[i] = win[i+1];
        win_d[W-1] = in_data;
      end
      if (in_ready && w_wr_en && (32'(w_wr_addr) < Kernel_Size))
        wt_d[w_wr_addr] = w_wr_data;
      unique case (state)
        FILL: begin
          if (accept) count_d = count + 1'b1;
          if (last_fill) begin
            load = 1'b1;
            k_d  = '0;
          end
        end
        SHIFT: begin
          if (last_shift) begin
            scnt_d = '0;
            load   = 1'b1;
            k_d    = '0;
          end else if (accept) begin
            scnt_d = scnt + 1'b1;
          end
        end
        COMPUTE: begin
          if (last_tap) begin
            gd_d = 1'b1;
          end else begin
            k_d  = k + 1'b1;
            tap  = k + 1'b1;
            load = 1'b1;
          end
        end
        DONE: begin
          scnt_d = '0;
          k_d    = '0;
        end
        default: ;
      endcase
      if (load) begin
        pv_d = 1'b1;
        ia_d = (tap == '0);
        for (int i = 0; i < Para_Deg; i++) begin
          d0_d[i*Data_Width +: Data_Width] = win_d[i + int'(tap)];
          d1_d[i*Data_Width +: Data_Width] = wt_d[tap];
        end
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count              <= '0;
      k                  <= '0;
      scnt               <= '0;
      data0              <= '0;
      data1              <= '0;
      Initial_Accumulate <= 1'b0;
      pe_valid           <= 1'b0;
      group_done         <= 1'b0;
      for (int i = 0; i < W; i++) win[i] <= '0;
      for (int i = 0; i < Kernel_Size; i++) wt[i] <= '0;
    end else begin
      count              <= count_d;
      k                  <= k_d;
      scnt               <= scnt_d;
      data0              <= d0_d;
      data1              <= d1_d;
      Initial_Accumulate <= ia_d;
      pe_valid           <= pv_d;
      group_done         <= gd_d;
      win                <= win_d;
      wt                 <= wt_d;
    end
  end

endmodule
